decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Parametrised Y86-64 decode stage with an integrated register file, E/M/W forwarding, load-use hazard detection and a registered D→E pipeline register. It sits between the fetch/D register and the execute stage. It replaces the purely combinational decode with a block that owns register-file state, generates its own stall request, and inserts bubbles into E. Data width and register-index width are generic, so the same block serves narrow test configurations.

## Interface
Parameters:
- XLEN, 64, data/register width
- RW, 4, register-index width
- RNONE, 2**RW-1, index meaning "no register"
- RSP, 4, stack-pointer index
- NOP_ICODE, 1, icode injected on bubble
- SAOK, 1, stat value injected on bubble

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D_stat, D_icode, D_ifun  in  4 each  decode-register fields
- D_rA, D_rB  in  RW  register specifiers
- D_valC, D_valP  in  XLEN  constant / next PC
- e_dstE  in  RW; e_valE  in  XLEN  execute-stage result
- E_dstM  in  RW; E_icode  in  4  current E-register fields, fed back for load-use detection
- M_dstE, M_dstM  in  RW; M_valE, m_valM  in  XLEN  memory-stage forwarding
- W_dstE, W_dstM  in  RW; W_valE, W_valM  in  XLEN  write-back ports, also the register-file write ports
- e_flush  in  1  branch mispredict / ret: bubble E next edge
- e_hold  in  1  downstream stall: hold E contents
- d_stall  out  1  combinational load-use stall request to F/D registers
- E_stat_o, E_icode_o, E_ifun_o  out  4  registered
- E_valC_o, E_valA_o, E_valB_o  out  XLEN  registered
- E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  RW  registered

## Operation
- Register file: 2**RW-1 entries of XLEN bits. Index RNONE is never written and reads as 0.
- Register-file writes occur on the rising edge: W_dstE←W_valE, then W_dstM←W_valM. If both indices match, W_valM wins.
- Source/destination selection per D_icode (any unlisted icode: all four = RNONE):
  - cmovXX(2): srcA=rA, dstE=rB
  - irmovq(3): dstE=rB
  - rmmovq(4): srcA=rA, srcB=rB
  - mrmovq(5): srcB=rB, dstM=rA
  - OPq(6): srcA=rA, srcB=rB, dstE=rB
  - call(8): srcB=RSP, dstE=RSP
  - ret(9): srcA=srcB=dstE=RSP
  - pushq(A): srcA=rA, srcB=dstE=RSP
  - popq(B): srcA=srcB=dstE=RSP, dstM=rA
- valA selection, first match wins:
  1. D_icode ∈ {7,8}: D_valP.
  2. Forwarding order: e_dstE→e_valE, M_dstM→m_valM, M_dstE→M_valE, W_dstM→W_valM, W_dstE→W_valE.
  3. Otherwise: register-file read.
  - A forwarding source matches only if its index equals the source index and the source index ≠ RNONE.
- valB uses the same forwarding order without the valP rule.
- Load-use: d_stall = (E_icode ∈ {5, B}) && E_dstM ≠ RNONE && (E_dstM == srcA || E_dstM == srcB).
- E register update, priority order:
  1. rst_n low: bubble.
  2. e_hold: keep contents.
  3. e_flush or d_stall: bubble.
  4. Otherwise: load decoded values.
- Bubble contents: stat=SAOK, icode=NOP_ICODE, ifun=0, all values 0, all indices RNONE.

## Timing
- Reset (async assert, sync-safe release):
  - every E output holds bubble values
  - all register-file entries = 0
  - d_stall = 0 while E_icode_o is NOP
- Decode→E latency: one cycle. Values forwarded in cycle n appear on E_*_o after edge n.
- d_stall is purely combinational from current inputs, with no internal state.
- A register-file write at edge n is visible to reads after edge n. Same-cycle reads see W values via forwarding.
- Simultaneous e_hold and e_flush: hold wins; flush is dropped. The owner must reassert flush.
- Reset asserted mid-operation clears E and the register file immediately, independent of clk.

## Test plan
- Reset: drive rst_n=0 mid-run → E_icode_o=1, E_dstE_o=15, E_valA_o=0 at once, without a clock edge.
- Write then read: W_dstE=3, W_valE=0x1234 for one edge; then OPq rA=3, rB=3 with no hazards → E_valA_o=E_valB_o=0x1234.
- Forward priority: srcA=2 with e_dstE=2/0xAA, M_dstE=2/0xBB, W_dstE=2/0xCC → E_valA_o=0xAA; drop e_dstE to RNONE → 0xBB.
- Load-use: E_icode=5, E_dstM=6, D is OPq rA=6 → d_stall=1 and next E is a bubble. When E_icode becomes NOP, E loads with valA=m_valM.
- call: D_icode=8, D_valP=0x40, reg[RSP]=0x100 → E_valA_o=0x40, E_valB_o=0x100, E_dstE_o=4.
- Flush vs hold: e_flush=1 alone → bubble; e_flush=e_hold=1 → E unchanged.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Y86-64 decode stage: register file, E/M/W forwarding, load-use stall detection
// and the registered D->E pipeline register with bubble/hold control.
module decode_stage_pipe #(
   parameter int unsigned   XLEN      = 64,
   parameter int unsigned   RW        = 4,
   parameter logic [RW-1:0] RNONE     = {RW{1'b1}},
   parameter logic [RW-1:0] RSP       = RW'(4),
   parameter logic [3:0]    NOP_ICODE = 4'h1,
   parameter logic [3:0]    SAOK      = 4'h1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      D_stat,
   input  logic [3:0]      D_icode,
   input  logic [3:0]      D_ifun,
   input  logic [RW-1:0]   D_rA,
   input  logic [RW-1:0]   D_rB,
   input  logic [XLEN-1:0] D_valC,
   input  logic [XLEN-1:0] D_valP,
   input  logic [RW-1:0]   e_dstE,
   input  logic [XLEN-1:0] e_valE,
   input  logic [RW-1:0]   E_dstM,
   input  logic [3:0]      E_icode,
   input  logic [RW-1:0]   M_dstE,
   input  logic [RW-1:0]   M_dstM,
   input  logic [XLEN-1:0] M_valE,
   input  logic [XLEN-1:0] m_valM,
   input  logic [RW-1:0]   W_dstE,
   input  logic [RW-1:0]   W_dstM,
   input  logic [XLEN-1:0] W_valE,
   input  logic [XLEN-1:0] W_valM,
   input  logic            e_flush,
   input  logic            e_hold,
   output logic            d_stall,
   output logic [3:0]      E_stat_o,
   output logic [3:0]      E_icode_o,
   output logic [3:0]      E_ifun_o,
   output logic [XLEN-1:0] E_valC_o,
   output logic [XLEN-1:0] E_valA_o,
   output logic [XLEN-1:0] E_valB_o,
   output logic [RW-1:0]   E_dstE_o,
   output logic [RW-1:0]   E_dstM_o,
   output logic [RW-1:0]   E_srcA_o,
   output logic [RW-1:0]   E_srcB_o
);

   localparam int unsigned NREG = 2**RW - 1;

   typedef enum logic [3:0] {
      I_HALT  = 4'h0,
      I_NOP   = 4'h1,
      I_CMOV  = 4'h2,
      I_IRMOV = 4'h3,
      I_RMMOV = 4'h4,
      I_MRMOV = 4'h5,
      I_OP    = 4'h6,
      I_JXX   = 4'h7,
      I_CALL  = 4'h8,
      I_RET   = 4'h9,
      I_PUSH  = 4'hA,
      I_POP   = 4'hB
   } icode_e;

   logic [XLEN-1:0] regs [NREG];
   logic [RW-1:0]   src_a, src_b, dst_e, dst_m;
   logic [XLEN-1:0] val_a, val_b;

   // Two writes per edge; the M port is applied last so it wins on a shared index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else begin
         if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
         if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
      end
   end

   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode_e'(D_icode))
         I_CMOV:  begin src_a = D_rA; dst_e = D_rB; end
         I_IRMOV: dst_e = D_rB;
         I_RMMOV: begin src_a = D_rA; src_b = D_rB; end
         I_MRMOV: begin src_b = D_rB; dst_m = D_rA; end
         I_OP:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
         I_CALL:  begin src_b = RSP; dst_e = RSP; end
         I_RET:   begin src_a = RSP; src_b = RSP; dst_e = RSP; end
         I_PUSH:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
         I_POP:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
         default: ;
      endcase
   end

   function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] src);
      if (src == RNONE)       return '0;
      else if (src == e_dstE) return e_valE;
      else if (src == M_dstM) return m_valM;
      else if (src == M_dstE) return M_valE;
      else if (src == W_dstM) return W_valM;
      else if (src == W_dstE) return W_valE;
      else                    return regs[src];
   endfunction

   always_comb begin
      val_a = fwd(src_a);
      if (D_icode == I_JXX || D_icode == I_CALL) val_a = D_valP;
      val_b = fwd(src_b);
   end

   assign d_stall = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != RNONE) &&
                    (E_dstM == src_a || E_dstM == src_b);

   // Hold outranks flush and stall; a flush raised during a hold is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         E_stat_o  <= SAOK;
         E_icode_o <= NOP_ICODE;
         E_ifun_o  <= '0;
         E_valC_o  <= '0;
         E_valA_o  <= '0;
         E_valB_o  <= '0;
         E_dstE_o  <= RNONE;
         E_dstM_o  <= RNONE;
         E_srcA_o  <= RNONE;
         E_srcB_o  <= RNONE;
      end else if (!e_hold) begin
         if (e_flush || d_stall) begin
            E_stat_o  <= SAOK;
            E_icode_o <= NOP_ICODE;
            E_ifun_o  <= '0;
            E_valC_o  <= '0;
            E_valA_o  <= '0;
            E_valB_o  <= '0;
            E_dstE_o  <= RNONE;
            E_dstM_o  <= RNONE;
            E_srcA_o  <= RNONE;
            E_srcB_o  <= RNONE;
         end else begin
            E_stat_o  <= D_stat;
            E_icode_o <= D_icode;
            E_ifun_o  <= D_ifun;
            E_valC_o  <= D_valC;
            E_valA_o  <= val_a;
            E_valB_o  <= val_b;
            E_dstE_o  <= dst_e;
            E_dstM_o  <= dst_m;
            E_srcA_o  <= src_a;
            E_srcB_o  <= src_b;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: expected E contents are queued when the
// decode inputs are driven and compared one cycle later.
module tb_decode_stage_pipe;
   localparam int unsigned XLEN = 64;
   localparam int unsigned RW   = 4;
   localparam logic [3:0]  RN   = 4'hF;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [3:0]      D_stat, D_icode, D_ifun;
   logic [RW-1:0]   D_rA, D_rB;
   logic [XLEN-1:0] D_valC, D_valP;
   logic [RW-1:0]   e_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [3:0]      E_icode;
   logic [XLEN-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic            e_flush, e_hold;
   logic            d_stall;
   logic [3:0]      E_stat_o, E_icode_o, E_ifun_o;
   logic [XLEN-1:0] E_valC_o, E_valA_o, E_valB_o;
   logic [RW-1:0]   E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;

   typedef struct {
      logic [3:0]  stat, icode, ifun;
      logic [63:0] valc, vala, valb;
      logic [3:0]  dste, dstm, srca, srcb;
   } e_t;

   e_t exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   decode_stage_pipe #(
      .XLEN(XLEN), .RW(RW), .RNONE(RN), .RSP(4'd4), .NOP_ICODE(4'h1), .SAOK(4'h1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE), .E_dstM(E_dstM), .E_icode(E_icode),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
      .e_flush(e_flush), .e_hold(e_hold), .d_stall(d_stall),
      .E_stat_o(E_stat_o), .E_icode_o(E_icode_o), .E_ifun_o(E_ifun_o),
      .E_valC_o(E_valC_o), .E_valA_o(E_valA_o), .E_valB_o(E_valB_o),
      .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic e_t mk(input logic [3:0] stat, icode, ifun,
                             input logic [63:0] valc, vala, valb,
                             input logic [3:0] dste, dstm, srca, srcb);
      e_t e;
      e.stat = stat; e.icode = icode; e.ifun = ifun;
      e.valc = valc; e.vala = vala; e.valb = valb;
      e.dste = dste; e.dstm = dstm; e.srca = srca; e.srcb = srcb;
      return e;
   endfunction

   function automatic e_t bubble();
      return mk(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, RN, RN, RN, RN);
   endfunction

   task automatic step(input string tag, input e_t e);
      e_t got;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk({tag, ".stat"},  64'(E_stat_o),  64'(got.stat));
      chk({tag, ".icode"}, 64'(E_icode_o), 64'(got.icode));
      chk({tag, ".ifun"},  64'(E_ifun_o),  64'(got.ifun));
      chk({tag, ".valC"},  E_valC_o,       got.valc);
      chk({tag, ".valA"},  E_valA_o,       got.vala);
      chk({tag, ".valB"},  E_valB_o,       got.valb);
      chk({tag, ".dstE"},  64'(E_dstE_o),  64'(got.dste));
      chk({tag, ".dstM"},  64'(E_dstM_o),  64'(got.dstm));
      chk({tag, ".srcA"},  64'(E_srcA_o),  64'(got.srca));
      chk({tag, ".srcB"},  64'(E_srcB_o),  64'(got.srcb));
   endtask

   task automatic set_idle();
      D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = RN; D_rB = RN;
      D_valC = '0; D_valP = '0;
      e_dstE = RN; e_valE = '0; E_dstM = RN; E_icode = 4'h1;
      M_dstE = RN; M_dstM = RN; M_valE = '0; m_valM = '0;
      W_dstE = RN; W_dstM = RN; W_valE = '0; W_valM = '0;
      e_flush = 1'b0; e_hold = 1'b0;
   endtask

   task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
      D_icode = icode; D_rA = ra; D_rB = rb;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      #1 rst_n = 1'b0;
      #1;
      chk("rst.icode", 64'(E_icode_o), 64'h1);
      chk("rst.dstE",  64'(E_dstE_o),  64'hF);
      chk("rst.valA",  E_valA_o,       64'h0);
      chk("rst.stat",  64'(E_stat_o),  64'h1);
      chk("rst.stall", 64'(d_stall),   64'h0);
      #1 rst_n = 1'b1;

      // register-file write then read
      W_dstE = 4'd3; W_valE = 64'h1234;
      step("wr3", bubble());
      set_idle(); set_d(4'h6, 4'd3, 4'd3);
      step("rd3", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h1234, 64'h1234, 4'd3, RN, 4'd3, 4'd3));

      // both W ports on one index: M port wins
      set_idle(); W_dstE = 4'd5; W_valE = 64'h11; W_dstM = 4'd5; W_valM = 64'h22;
      step("dualw", bubble());
      set_idle(); set_d(4'h6, 4'd5, RN);
      step("rd5", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h22, 64'h0, RN, RN, 4'd5, RN));

      // forwarding priority on srcA
      set_idle(); set_d(4'h6, 4'd2, RN);
      e_dstE = 4'd2; e_valE = 64'hAA; M_dstE = 4'd2; M_valE = 64'hBB;
      W_dstE = 4'd2; W_valE = 64'hCC;
      step("fwd_e", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'hAA, 64'h0, RN, RN, 4'd2, RN));
      e_dstE = RN;
      step("fwd_M", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'hBB, 64'h0, RN, RN, 4'd2, RN));
      M_dstM = 4'd2; m_valM = 64'hDD;
      step("fwd_mM", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'hDD, 64'h0, RN, RN, 4'd2, RN));
      M_dstM = RN; M_dstE = RN; W_dstM = 4'd2; W_valM = 64'hEE;
      step("fwd_WM", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'hEE, 64'h0, RN, RN, 4'd2, RN));
      W_dstM = RN; W_dstE = RN;
      step("rf2", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'hEE, 64'h0, RN, RN, 4'd2, RN));

      // valB forwarding; RNONE source must not pick up a forwarded value
      set_idle(); set_d(4'h4, RN, 4'd2); D_valC = 64'h8;
      e_dstE = 4'd2; e_valE = 64'h5; M_valE = 64'h99;
      step("fwd_b", mk(4'h1, 4'h4, 4'h0, 64'h8, 64'h0, 64'h5, RN, RN, RN, 4'd2));

      // load-use hazard
      set_idle(); E_icode = 4'h5; E_dstM = 4'd6; set_d(4'h6, 4'd6, 4'd6);
      #1 chk("lu.stall", 64'(d_stall), 64'h1);
      step("lu_bub", bubble());
      E_icode = 4'h1; E_dstM = RN; M_dstM = 4'd6; m_valM = 64'h77;
      #1 chk("lu.clear", 64'(d_stall), 64'h0);
      step("lu_go", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h77, 64'h77, 4'd6, RN, 4'd6, 4'd6));
      set_idle(); E_icode = 4'hB; E_dstM = 4'd4; set_d(4'hA, 4'd1, RN);
      #1 chk("lu.pop_srcB", 64'(d_stall), 64'h1);
      step("lu_pop", bubble());
      set_idle(); E_icode = 4'h5; E_dstM = RN; set_d(4'h6, RN, RN);
      #1 chk("lu.rnone", 64'(d_stall), 64'h0);
      E_icode = 4'h6; E_dstM = 4'd6; set_d(4'h6, 4'd6, RN);
      #1 chk("lu.notload", 64'(d_stall), 64'h0);
      step("lu_nl", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, RN, RN, 4'd6, RN));

      // call: valA = valP, valB = reg[RSP]
      set_idle(); W_dstM = 4'd4; W_valM = 64'h100;
      step("wrsp", bubble());
      set_idle(); set_d(4'h8, 4'd1, 4'd2); D_valP = 64'h40; D_valC = 64'h99;
      step("call", mk(4'h1, 4'h8, 4'h0, 64'h99, 64'h40, 64'h100, 4'd4, RN, RN, 4'd4));
      set_idle(); set_d(4'h7, 4'd3, 4'd3); D_stat = 4'h2; D_ifun = 4'h3;
      D_valP = 64'h58; D_valC = 64'h200;
      step("jxx", mk(4'h2, 4'h7, 4'h3, 64'h200, 64'h58, 64'h0, RN, RN, RN, RN));

      // flush versus hold
      set_idle(); set_d(4'h3, RN, 4'd7); D_valC = 64'h55; e_flush = 1'b1;
      step("flush", bubble());
      e_flush = 1'b0;
      step("irmov", mk(4'h1, 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'd7, RN, RN, RN));
      set_d(4'h6, 4'd3, 4'd3); e_flush = 1'b1; e_hold = 1'b1;
      step("hold_fl", mk(4'h1, 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'd7, RN, RN, RN));
      e_flush = 1'b0; E_icode = 4'h5; E_dstM = 4'd3;
      step("hold_st", mk(4'h1, 4'h3, 4'h0, 64'h55, 64'h0, 64'h0, 4'd7, RN, RN, RN));

      // mid-run asynchronous reset clears E and the register file
      set_idle(); set_d(4'h6, 4'd3, 4'd3);
      step("pre_rst", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h1234, 64'h1234, 4'd3, RN, 4'd3, 4'd3));
      rst_n = 1'b0;
      #1;
      chk("arst.icode", 64'(E_icode_o), 64'h1);
      chk("arst.dstE",  64'(E_dstE_o),  64'hF);
      chk("arst.valA",  E_valA_o,       64'h0);
      chk("arst.valB",  E_valB_o,       64'h0);
      #2 rst_n = 1'b1;
      set_idle(); set_d(4'h6, 4'd3, 4'd5);
      step("rf_clr", mk(4'h1, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'd5, RN, 4'd3, 4'd5));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
